smem_banked: RTL

//  Parametrised multi-bank shared memory for one SM: serves a warp-wide request of NUM_LANES lanes.

---
 rtl/smem_banked.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/smem_banked.sv
// rtl/smem_banked.sv - banked shared memory serving warp-wide lane requests
//
// Purpose:
//   Multi-bank shared memory for one SM. A request carries NUM_LANES lanes,
//   and each lane has its own address and write data. Words are interleaved
//   across NUM_BANKS single-port banks: bank = addr[BW-1:0] and
//   row = addr[ADDR_W-1:BW].
//   In each SERVE cycle, every bank serves its lowest-index pending lane.
//   The request completes with a one-cycle finish pulse. That pulse carries
//   the gathered read data and the number of service cycles used.
//
// Configuration macro:
//   SMEM_BROADCAST_EN - when defined, a read lets every pending lane with the
//   same full address as the bank's selected lane share that bank cycle.
//   When undefined, every lane costs one bank cycle.
//
// Ports:
//   clock_i       clock, rising edge
//   reset_i       synchronous active-high reset
//   req_valid_i   request present
//   req_ready_o   block idle and able to accept
//   req_write_i   1 = active lanes write, 0 = active lanes read
//   req_mask_i    per-lane active bits
//   req_addr_i    lane i address at [i*ADDR_W +: ADDR_W]
//   req_wdata_i   lane i write data at [i*DATA_W +: DATA_W]
//   finish_o      one-cycle completion pulse
//   rsp_data_o    gathered read data, lane i at [i*DATA_W +: DATA_W]
//   rsp_cycles_o  service cycles used by the last request
module smem_banked #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int NUM_BANKS = 4,
  parameter int NUM_LANES = 4
) (
  input  logic                            clock_i,
  input  logic                            reset_i,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic                            req_write_i,
  input  logic [NUM_LANES-1:0]            req_mask_i,
  input  logic [NUM_LANES*ADDR_W-1:0]     req_addr_i,
  input  logic [NUM_LANES*DATA_W-1:0]     req_wdata_i,
  output logic                            finish_o,
  output logic [NUM_LANES*DATA_W-1:0]     rsp_data_o,
  output logic [$clog2(NUM_LANES+1)-1:0]  rsp_cycles_o
);

  localparam int BW    = $clog2(NUM_BANKS);
  localparam int ROW_W = ADDR_W - BW;
  localparam int ROWS  = 1 << ROW_W;
  localparam int LW    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CW    = $clog2(NUM_LANES + 1);

`ifdef SMEM_BROADCAST_EN
  localparam bit BCAST_EN = 1'b1;
`else
  localparam bit BCAST_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SERVE, S_DONE} state_e;

  state_e                      state_q;
  logic                        write_q;
  logic [NUM_LANES-1:0]        pending_q;
  logic [ADDR_W-1:0]           addr_q  [NUM_LANES];
  logic [DATA_W-1:0]           wdata_q [NUM_LANES];
  logic [NUM_LANES*DATA_W-1:0] rsp_data_q;
  logic [CW-1:0]               rsp_cycles_q;
  logic                        finish_q;

  // One storage array per bank; each bank sees at most one access per cycle.
  logic [DATA_W-1:0]           mem_q [NUM_BANKS][ROWS];

  logic [NUM_LANES-1:0][BW-1:0] lane_bank;
  logic [NUM_BANKS-1:0]         sel_vld;
  logic [NUM_BANKS-1:0][LW-1:0] sel_idx;
  logic [ADDR_W-1:0]            sel_addr [NUM_BANKS];
  logic [DATA_W-1:0]            rd_word  [NUM_BANKS];
  logic [NUM_LANES-1:0]         served;
  logic [NUM_LANES-1:0]         pending_d;

  // Per-bank arbitration. The scan runs from the top lane down, so the last
  // assignment wins and the lowest pending lane is chosen.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_bank[i] = addr_q[i][BW-1:0];
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      sel_vld[b] = 1'b0;
      sel_idx[b] = '0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
        if (pending_q[i] && (lane_bank[i] == BW'(b))) begin
          sel_vld[b] = 1'b1;
          sel_idx[b] = LW'(i);
        end
      end
      sel_addr[b] = addr_q[sel_idx[b]];
      rd_word[b]  = mem_q[b][sel_addr[b][ADDR_W-1:BW]];
    end
  end

  // A lane is served when its bank picked it. With broadcast enabled, a
  // read lane is also served when it targets the word its bank is reading.
  always_comb begin
    served = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (pending_q[i] && sel_vld[lane_bank[i]]) begin
        if ((sel_idx[lane_bank[i]] == LW'(i)) ||
            (BCAST_EN && !write_q && (addr_q[i] == sel_addr[lane_bank[i]]))) begin
          served[i] = 1'b1;
        end
      end
    end
    pending_d = pending_q & ~served;
  end

  // Bank writes. Lanes that hit the same word are served in ascending lane
  // order, so the highest active lane's data is the value that remains.
  // Writes are suppressed on a reset edge so that an aborted request stops
  // immediately.
  always_ff @(posedge clock_i) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (!reset_i && (state_q == S_SERVE) && write_q && sel_vld[b]) begin
        mem_q[b][sel_addr[b][ADDR_W-1:BW]] <= wdata_q[sel_idx[b]];
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      finish_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_cycles_q <= '0;
      pending_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          finish_q <= 1'b0;
          if (req_valid_i) begin
            write_q      <= req_write_i;
            pending_q    <= req_mask_i;
            rsp_data_q   <= '0;
            rsp_cycles_q <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
              addr_q[i]  <= req_addr_i[i*ADDR_W +: ADDR_W];
              wdata_q[i] <= req_wdata_i[i*DATA_W +: DATA_W];
            end
            if (req_mask_i == '0) begin
              state_q  <= S_DONE;
              finish_q <= 1'b1;
            end else begin
              state_q <= S_SERVE;
            end
          end
        end
        S_SERVE: begin
          pending_q    <= pending_d;
          rsp_cycles_q <= rsp_cycles_q + CW'(1);
          if (!write_q) begin
            for (int i = 0; i < NUM_LANES; i++) begin
              if (served[i]) begin
                rsp_data_q[i*DATA_W +: DATA_W] <= rd_word[lane_bank[i]];
              end
            end
          end
          // finish is raised on the same edge that enters DONE, so the
          // pulse coincides with the DONE cycle.
          if (pending_d == '0) begin
            state_q  <= S_DONE;
            finish_q <= 1'b1;
          end
        end
        S_DONE: begin
          finish_q <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: begin
          finish_q <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign finish_o     = finish_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_cycles_o = rsp_cycles_q;

endmodule
